sd_data_phy: RTL and testbench
==============================

SD_DATA_PHY -- requirements
Module: sd_data_phy

Interface
REQ-001 Parameter BLOCK_WORDS, default 128, meaning 32-bit words per block (128 = 512 bytes).
REQ-002 SD_clock  in  1  sole clock; all logic on rising edge.
REQ-003 Reset  in  1  synchronous, active-low; 0 at a rising edge resets the block.
REQ-004 Send  in  1  start one block transfer; sampled only in IDLE.
REQ-005 WriteRead  in  1  1 = transmit block to card, 0 = receive block from card; sampled with Send.
REQ-006 Idle  in  1  abort; force IDLE.
REQ-007 Timeout_enable  in  1  enables timeout counting.
REQ-008 Timeout_reg  in  16  timeout limit, in SD_clock cycles.
REQ-009 Data_from_FIFO  in  32  transmit word; first-word-fall-through FIFO; captured in the cycle ReadEn is 1.
REQ-010 ReadEn  out  1  one-cycle FIFO pop.
REQ-011 Data_to_FIFO  out  32  received word; valid while WriteEn is 1.
REQ-012 WriteEn  out  1  one-cycle FIFO push.
REQ-013 Data_pin_in  in  1  DAT0 from card.
REQ-014 Data_pin_out  out  1  DAT0 to card.
REQ-015 Data_pin_oe  out  1  1 = block drives DAT0.
REQ-016 Serial_ready  out  1  1 exactly while in IDLE.
REQ-017 Complete  out  1  one-cycle pulse; block finished.
REQ-018 CRC_error  out  1  one-cycle pulse, coincident with Complete, on bad receive CRC or end bit.
REQ-019 Timeout  out  1  one-cycle pulse on timeout.

Function
REQ-020 States SHALL be IDLE, TX_START, TX_DATA, TX_CRC, TX_END, TX_BUSY, RX_WAIT, RX_DATA, RX_CRC, RX_END.
REQ-021 IDLE: Data_pin_oe 0, Data_pin_out 1; Send=1 -> TX_START if WriteRead=1, else RX_WAIT.
REQ-022 TX_START (1 cycle): oe 1, out 0 (start bit); ReadEn 1, word 0 captured into shift register.
REQ-023 TX_DATA: one bit per cycle, MSB first, 32*BLOCK_WORDS cycles; ReadEn 1 during bit 0 of every word except the last, so the next word's bit 31 follows without a gap.
REQ-024 TX_CRC: 16 cycles of CRC16 (x^16+x^12+x^5+1, init 0) over data bits only, MSB first.
REQ-025 TX_END: 1 cycle, out 1; then oe 0 and -> TX_BUSY.
REQ-026 TX_BUSY: counter runs; Data_pin_in=1 -> Complete pulse, -> IDLE.
REQ-027 A transmit frame is exactly 1+32*BLOCK_WORDS+16+1 driven cycles.
REQ-028 RX_WAIT: counter runs; Data_pin_in=0 (start bit) -> RX_DATA.
REQ-029 RX_DATA: shift Data_pin_in MSB first, 32*BLOCK_WORDS cycles; on each 32nd bit, WriteEn 1 and Data_to_FIFO = assembled word in the following cycle.
REQ-030 RX_CRC: 16 cycles; received bits compared with the computed CRC.
REQ-031 RX_END: 1 cycle; Complete pulse; CRC_error pulse if the CRC mismatched or the end bit is 0; -> IDLE.
REQ-032 Timeout counter: 16 bits; cleared on entry to RX_WAIT or TX_BUSY; 0 in the first cycle there; +1 per cycle; saturates at FFFF.
REQ-033 If Timeout_enable=1 and counter==Timeout_reg: Timeout pulse, no Complete, -> IDLE; Timeout_reg=0 fires in the first cycle.
REQ-034 Idle=1 in any state: next cycle IDLE, oe 0, no Complete/Timeout/CRC_error pulse, CRC and counters cleared.
REQ-035 Idle and Send both 1: Idle wins. Send outside IDLE is ignored.
REQ-036 Start bit and timeout match in the same RX_WAIT cycle: start bit wins.

Reset
REQ-037 On Reset=0: state IDLE; Data_pin_out 1; all other outputs 0 except Serial_ready 1; shift register, CRC and counters 0.
REQ-038 Reset mid-frame releases DAT0 (oe 0) on the next edge; no partial FIFO push.

Structure
REQ-039 Package sd_data_pkg SHALL hold the state enum, the CRC16 polynomial constant 16'h1021 and the BLOCK_WORDS default.
REQ-040 A single sub-module, sd_crc16, SHALL implement the serial CRC (inputs clear, enable, bit; output crc[15:0]), shared by TX and RX.

Verification
REQ-041 BLOCK_WORDS=1, WriteRead=1, Send pulse, Data_from_FIFO=0 -> pin: 0, 32 zeros, 16 zeros, 1; ReadEn exactly once; Complete 1 cycle after Data_pin_in=1.
REQ-042 BLOCK_WORDS=2, words 32'hA5A5_0F0F and 32'h1234_5678 -> 64 bits MSB first, no gap; ReadEn twice; CRC equals the reference model.
REQ-043 RX, BLOCK_WORDS=1, card sends 0, 32'hDEADBEEF, correct CRC, 1 -> WriteEn once with Data_to_FIFO=DEADBEEF, Complete 1, CRC_error 0.
REQ-044 Same frame with one CRC bit flipped (separately, end bit 0) -> Complete 1 with CRC_error 1.
REQ-045 RX, Timeout_enable=1, Timeout_reg=70, DAT0 held high -> Timeout pulse 71 cycles after RX_WAIT entry; Serial_ready 1 next cycle.
REQ-046 Idle asserted at TX_DATA bit 10 -> next cycle IDLE, oe 0, no Complete; a new Send starts cleanly.

Source files
------------

// File: rtl/sd_data_pkg.sv
// SD DAT0 serial PHY: shared state encoding and CRC constants.
package sd_data_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int BLOCK_WORDS_DEF = 128;

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_CRC,
    TX_END,
    TX_BUSY,
    RX_WAIT,
    RX_DATA,
    RX_CRC,
    RX_END
  } state_t;

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1), zero init, one bit per enabled cycle.
module sd_crc16
  import sd_data_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic fb;

  assign fb = bit_in ^ crc[15];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_data_phy.sv
// SD DAT0 block transfer engine: framed TX with busy wait, framed RX
// with CRC check, shared timeout counter and abort.
module sd_data_phy
  import sd_data_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic        SD_clock,
  input  logic        Reset,
  input  logic        Send,
  input  logic        WriteRead,
  input  logic        Idle,
  input  logic        Timeout_enable,
  input  logic [15:0] Timeout_reg,
  input  logic [31:0] Data_from_FIFO,
  output logic        ReadEn,
  output logic [31:0] Data_to_FIFO,
  output logic        WriteEn,
  input  logic        Data_pin_in,
  output logic        Data_pin_out,
  output logic        Data_pin_oe,
  output logic        Serial_ready,
  output logic        Complete,
  output logic        CRC_error,
  output logic        Timeout
);

  localparam int NBITS = 32 * BLOCK_WORDS;
  localparam int BCW = $clog2(NBITS);
  localparam logic [BCW-1:0] LAST = BCW'(NBITS - 1);

  state_t state, state_nxt;

  logic [31:0]    shreg;
  logic [BCW-1:0] bcnt;
  logic [15:0]    tcnt;
  logic [15:0]    crc;
  logic           crc_bad;
  logic           crc_clr;
  logic           crc_en;
  logic           crc_bit;
  logic           crc_tx;
  logic           word_end;
  logic           last_bit;
  logic           crc_last;
  logic           tmo_hit;
  logic           done;
  logic           tmo_ev;

  assign word_end = (bcnt[4:0] == 5'd31);
  assign last_bit = (bcnt == LAST);
  assign crc_last = (bcnt[3:0] == 4'd15);
  assign crc_tx = crc[4'd15 - bcnt[3:0]];
  assign tmo_hit = Timeout_enable && (tcnt == Timeout_reg);
  assign crc_clr = Idle || (state == IDLE);
  assign Serial_ready = (state == IDLE);

  sd_crc16 u_crc (
    .clk    (SD_clock),
    .rst_n  (Reset),
    .clear  (crc_clr),
    .enable (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  always_ff @(posedge SD_clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    Data_pin_oe  = 1'b0;
    Data_pin_out = 1'b1;
    ReadEn       = 1'b0;
    crc_en       = 1'b0;
    crc_bit      = 1'b0;
    done         = 1'b0;
    tmo_ev       = 1'b0;
    unique case (state)
      IDLE: begin
        if (Send) state_nxt = WriteRead ? TX_START : RX_WAIT;
      end
      TX_START: begin
        Data_pin_oe  = 1'b1;
        Data_pin_out = 1'b0;
        ReadEn       = 1'b1;
        state_nxt    = TX_DATA;
      end
      TX_DATA: begin
        Data_pin_oe  = 1'b1;
        Data_pin_out = shreg[31];
        crc_en       = 1'b1;
        crc_bit      = shreg[31];
        // refill on the LSB so the next MSB follows with no gap
        ReadEn       = word_end && !last_bit;
        if (last_bit) state_nxt = TX_CRC;
      end
      TX_CRC: begin
        Data_pin_oe  = 1'b1;
        Data_pin_out = crc_tx;
        if (crc_last) state_nxt = TX_END;
      end
      TX_END: begin
        Data_pin_oe = 1'b1;
        state_nxt   = TX_BUSY;
      end
      TX_BUSY: begin
        if (Data_pin_in) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          tmo_ev    = 1'b1;
          state_nxt = IDLE;
        end
      end
      RX_WAIT: begin
        if (!Data_pin_in) begin
          state_nxt = RX_DATA;
        end else if (tmo_hit) begin
          tmo_ev    = 1'b1;
          state_nxt = IDLE;
        end
      end
      RX_DATA: begin
        crc_en  = 1'b1;
        crc_bit = Data_pin_in;
        if (last_bit) state_nxt = RX_CRC;
      end
      RX_CRC: begin
        if (crc_last) state_nxt = RX_END;
      end
      RX_END: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (Idle) begin
      state_nxt = IDLE;
      ReadEn    = 1'b0;
      crc_en    = 1'b0;
      done      = 1'b0;
      tmo_ev    = 1'b0;
    end
  end

  always_ff @(posedge SD_clock) begin
    if (!Reset) begin
      shreg        <= '0;
      bcnt         <= '0;
      tcnt         <= '0;
      crc_bad      <= 1'b0;
      WriteEn      <= 1'b0;
      Data_to_FIFO <= '0;
      Complete     <= 1'b0;
      CRC_error    <= 1'b0;
      Timeout      <= 1'b0;
    end else begin
      Complete  <= done;
      CRC_error <= done && (state == RX_END) &&
                   (crc_bad || !Data_pin_in);
      Timeout   <= tmo_ev;
      WriteEn   <= 1'b0;

      if (state_nxt != state) bcnt <= '0;
      else if (state inside {TX_DATA, TX_CRC, RX_DATA, RX_CRC})
        bcnt <= bcnt + 1'b1;

      if (state_nxt != state) tcnt <= '0;
      else if (state inside {TX_BUSY, RX_WAIT} && tcnt != 16'hFFFF)
        tcnt <= tcnt + 1'b1;

      if (Idle || state == IDLE) crc_bad <= 1'b0;
      else if (state == RX_CRC && Data_pin_in != crc_tx) crc_bad <= 1'b1;

      if (Idle) begin
        shreg <= '0;
      end else if (ReadEn) begin
        shreg <= Data_from_FIFO;
      end else if (state == TX_DATA) begin
        shreg <= {shreg[30:0], 1'b0};
      end else if (state == RX_DATA) begin
        shreg <= {shreg[30:0], Data_pin_in};
        if (word_end) begin
          WriteEn      <= 1'b1;
          Data_to_FIFO <= {shreg[30:0], Data_pin_in};
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_data_phy.sv
// Self-checking bench for sd_data_phy: randomized TX/RX frames checked
// against a frame-level model (polynomial-division CRC, word FIFO).
module tb_sd_data_phy;

  localparam int BW = 2;

  logic        SD_clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Send = 1'b0;
  logic        WriteRead = 1'b0;
  logic        Idle = 1'b0;
  logic        Timeout_enable = 1'b0;
  logic [15:0] Timeout_reg = '0;
  logic [31:0] Data_from_FIFO = '0;
  logic        Data_pin_in = 1'b1;
  logic        ReadEn;
  logic [31:0] Data_to_FIFO;
  logic        WriteEn;
  logic        Data_pin_out;
  logic        Data_pin_oe;
  logic        Serial_ready;
  logic        Complete;
  logic        CRC_error;
  logic        Timeout;

  int n_cmp = 0;
  int n_bad = 0;

  sd_data_phy #(.BLOCK_WORDS(BW)) dut (
    .SD_clock       (SD_clock),
    .Reset          (Reset),
    .Send           (Send),
    .WriteRead      (WriteRead),
    .Idle           (Idle),
    .Timeout_enable (Timeout_enable),
    .Timeout_reg    (Timeout_reg),
    .Data_from_FIFO (Data_from_FIFO),
    .ReadEn         (ReadEn),
    .Data_to_FIFO   (Data_to_FIFO),
    .WriteEn        (WriteEn),
    .Data_pin_in    (Data_pin_in),
    .Data_pin_out   (Data_pin_out),
    .Data_pin_oe    (Data_pin_oe),
    .Serial_ready   (Serial_ready),
    .Complete       (Complete),
    .CRC_error      (CRC_error),
    .Timeout        (Timeout)
  );

  always #5 SD_clock = ~SD_clock;

  task automatic tick();
    @(posedge SD_clock);
    #1;
  endtask

  // Remainder of (message * x^16) mod 0x11021
  function automatic logic [15:0] ref_crc(input logic m[$]);
    logic [16:0] r;
    r = '0;
    for (int i = 0; i < m.size() + 16; i++) begin
      r = {r[15:0], (i < m.size()) ? m[i] : 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  function automatic void data_bits(input logic [31:0] w0, w1,
                                    output logic d[$]);
    logic [63:0] v;
    v = {w0, w1};
    d = {};
    for (int i = 63; i >= 0; i--) d.push_back(v[i]);
  endfunction

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (Data_pin_out !== 1'b1 || Data_pin_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pin: out %b oe %b want 1 0",
               Data_pin_out, Data_pin_oe);
    end
    n_cmp++;
    if (ReadEn !== 1'b0 || WriteEn !== 1'b0 || Data_to_FIFO !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_fifo: re %b we %b data %h want 0 0 0",
               ReadEn, WriteEn, Data_to_FIFO);
    end
    n_cmp++;
    if (Serial_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", Serial_ready);
    end
    n_cmp++;
    if (Complete !== 1'b0 || CRC_error !== 1'b0 || Timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pulses: cmp %b err %b tmo %b want 0 0 0",
               Complete, CRC_error, Timeout);
    end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_tx(input logic [31:0] w0, w1,
                         input int busy, input int tmo);
    logic [31:0] w[2];
    logic d[$];
    logic exp[$];
    logic got[$];
    logic [15:0] c;
    int fi, nre, bad_at;
    logic re, oe_bad, flag;
    w[0] = w0;
    w[1] = w1;
    data_bits(w0, w1, d);
    c = ref_crc(d);
    exp.push_back(1'b0);
    foreach (d[i]) exp.push_back(d[i]);
    for (int i = 15; i >= 0; i--) exp.push_back(c[i]);
    exp.push_back(1'b1);
    Timeout_enable = (tmo >= 0);
    Timeout_reg = (tmo >= 0) ? 16'(tmo) : 16'hFFFF;
    WriteRead = 1'b1;
    Data_pin_in = 1'b0;
    fi = 0;
    Data_from_FIFO = w[0];
    Send = 1'b1;
    tick();
    nre = 0;
    bad_at = -1;
    oe_bad = 1'b0;
    for (int i = 0; i < exp.size(); i++) begin
      if (Data_pin_oe !== 1'b1) oe_bad = 1'b1;
      got.push_back(Data_pin_out);
      if (bad_at < 0 && Data_pin_out !== exp[i]) bad_at = i;
      re = ReadEn;
      if (re === 1'b1) nre++;
      Send = 1'($urandom_range(0, 1));
      tick();
      if (re === 1'b1) begin
        fi++;
        Data_from_FIFO = (fi < 2) ? w[fi] : $urandom;
      end
    end
    n_cmp++;
    if (bad_at >= 0 || oe_bad) begin
      n_bad++;
      $display("FAIL tx_frame: bit %0d got %b want %b oe_bad %b crc %h",
               bad_at, (bad_at >= 0) ? got[bad_at] : 1'b0,
               (bad_at >= 0) ? exp[bad_at] : 1'b0, oe_bad, c);
    end
    n_cmp++;
    if (nre != BW) begin
      n_bad++;
      $display("FAIL tx_readen: got %0d pops want %0d", nre, BW);
    end
    n_cmp++;
    if (Data_pin_oe !== 1'b0 || Serial_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_busy_enter: oe %b ready %b want 0 0",
               Data_pin_oe, Serial_ready);
    end
    flag = 1'b0;
    if (tmo < 0) begin
      for (int b = 0; b < busy; b++) begin
        if (Complete !== 1'b0 || Serial_ready !== 1'b0) flag = 1'b1;
        Send = 1'($urandom_range(0, 1));
        tick();
      end
      Send = 1'b0;
      n_cmp++;
      if (flag) begin
        n_bad++;
        $display("FAIL tx_busy_wait: early done/ready got 1 want 0");
      end
      Data_pin_in = 1'b1;
      tick();
      n_cmp++;
      if (Complete !== 1'b1 || Serial_ready !== 1'b1 || Timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL tx_complete: cmp %b ready %b tmo %b want 1 1 0",
                 Complete, Serial_ready, Timeout);
      end
      tick();
      n_cmp++;
      if (Complete !== 1'b0) begin
        n_bad++;
        $display("FAIL tx_complete_len: got %b want 0", Complete);
      end
    end else begin
      for (int k = 0; k <= tmo; k++) begin
        if (Timeout !== 1'b0 || Serial_ready !== 1'b0) flag = 1'b1;
        Send = 1'($urandom_range(0, 1));
        tick();
      end
      Send = 1'b0;
      n_cmp++;
      if (flag) begin
        n_bad++;
        $display("FAIL tx_tmo_early: got early timeout/ready want none");
      end
      n_cmp++;
      if (Timeout !== 1'b1 || Complete !== 1'b0 || Serial_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL tx_tmo: tmo %b cmp %b ready %b want 1 0 1",
                 Timeout, Complete, Serial_ready);
      end
      Data_pin_in = 1'b1;
      tick();
      n_cmp++;
      if (Timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL tx_tmo_len: got %b want 0", Timeout);
      end
    end
    Timeout_enable = 1'b0;
  endtask

  task automatic test_rx(input logic [31:0] w0, w1, input int flip,
                         input logic endb, input int delay);
    logic d[$];
    logic fr[$];
    logic [31:0] got[$];
    logic [15:0] c;
    logic exp_err, tmo_seen;
    data_bits(w0, w1, d);
    c = ref_crc(d);
    if (flip >= 0) c[15-flip] = ~c[15-flip];
    exp_err = (flip >= 0) || !endb;
    fr.push_back(1'b0);
    foreach (d[i]) fr.push_back(d[i]);
    for (int i = 15; i >= 0; i--) fr.push_back(c[i]);
    fr.push_back(endb);
    WriteRead = 1'b0;
    Data_pin_in = 1'b1;
    Send = 1'b1;
    tick();
    Send = 1'b0;
    tmo_seen = 1'b0;
    for (int k = 0; k < delay; k++) begin
      if (Timeout === 1'b1) tmo_seen = 1'b1;
      Send = 1'($urandom_range(0, 1));
      tick();
    end
    for (int i = 0; i < fr.size(); i++) begin
      Data_pin_in = fr[i];
      Send = 1'($urandom_range(0, 1));
      tick();
      if (Timeout === 1'b1) tmo_seen = 1'b1;
      if (WriteEn === 1'b1) got.push_back(Data_to_FIFO);
    end
    Send = 1'b0;
    n_cmp++;
    if (got.size() != BW || got[0] !== w0 || got[1] !== w1) begin
      n_bad++;
      $display("FAIL rx_words: got %0d words %h %h want 2 words %h %h",
               got.size(), (got.size() > 0) ? got[0] : 32'h0,
               (got.size() > 1) ? got[1] : 32'h0, w0, w1);
    end
    n_cmp++;
    if (Complete !== 1'b1 || CRC_error !== exp_err || Serial_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rx_status: cmp %b err %b ready %b want 1 %b 1",
               Complete, CRC_error, Serial_ready, exp_err);
    end
    n_cmp++;
    if (tmo_seen) begin
      n_bad++;
      $display("FAIL rx_no_tmo: timeout got 1 want 0");
    end
    Data_pin_in = 1'b1;
    tick();
    n_cmp++;
    if (Complete !== 1'b0 || CRC_error !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_pulse_len: cmp %b err %b want 0 0",
               Complete, CRC_error);
    end
  endtask

  task automatic test_rx_timeout(input logic [15:0] t);
    logic flag;
    Timeout_enable = 1'b1;
    Timeout_reg = t;
    WriteRead = 1'b0;
    Data_pin_in = 1'b1;
    Send = 1'b1;
    tick();
    Send = 1'b0;
    flag = 1'b0;
    for (int k = 0; k <= int'(t); k++) begin
      if (Timeout !== 1'b0 || Serial_ready !== 1'b0 || Complete !== 1'b0)
        flag = 1'b1;
      tick();
    end
    n_cmp++;
    if (flag) begin
      n_bad++;
      $display("FAIL rx_tmo_early: t=%0d early pulse/ready want none", t);
    end
    n_cmp++;
    if (Timeout !== 1'b1 || Complete !== 1'b0 || Serial_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rx_tmo: t=%0d tmo %b cmp %b ready %b want 1 0 1",
               t, Timeout, Complete, Serial_ready);
    end
    tick();
    n_cmp++;
    if (Timeout !== 1'b0 || Serial_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rx_tmo_after: tmo %b ready %b want 0 1",
               Timeout, Serial_ready);
    end
    Timeout_enable = 1'b0;
  endtask

  task automatic test_abort_tx();
    logic [31:0] w;
    w = $urandom;
    WriteRead = 1'b1;
    Data_from_FIFO = w;
    Data_pin_in = 1'b0;
    Send = 1'b1;
    tick();
    Send = 1'b0;
    repeat (11) tick();
    n_cmp++;
    if (Data_pin_oe !== 1'b1 || Data_pin_out !== w[21]) begin
      n_bad++;
      $display("FAIL abort_tx_bit10: oe %b out %b want 1 %b",
               Data_pin_oe, Data_pin_out, w[21]);
    end
    Idle = 1'b1;
    tick();
    Idle = 1'b0;
    n_cmp++;
    if (Data_pin_oe !== 1'b0 || Serial_ready !== 1'b1 ||
        Complete !== 1'b0 || Data_pin_out !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_tx: oe %b ready %b cmp %b out %b want 0 1 0 1",
               Data_pin_oe, Serial_ready, Complete, Data_pin_out);
    end
    Data_pin_in = 1'b1;
    tick();
    n_cmp++;
    if (Complete !== 1'b0 || Timeout !== 1'b0 || Serial_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_tx_after: cmp %b tmo %b ready %b want 0 0 1",
               Complete, Timeout, Serial_ready);
    end
  endtask

  task automatic test_abort_rx();
    WriteRead = 1'b0;
    Data_pin_in = 1'b1;
    Send = 1'b1;
    tick();
    Send = 1'b0;
    Data_pin_in = 1'b0;
    tick();
    repeat (5) begin
      Data_pin_in = 1'($urandom_range(0, 1));
      tick();
    end
    Idle = 1'b1;
    Send = 1'b1;
    tick();
    n_cmp++;
    if (Serial_ready !== 1'b1 || WriteEn !== 1'b0 ||
        Complete !== 1'b0 || CRC_error !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_rx: ready %b we %b cmp %b err %b want 1 0 0 0",
               Serial_ready, WriteEn, Complete, CRC_error);
    end
    tick();
    n_cmp++;
    if (Serial_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_beats_send: ready %b want 1", Serial_ready);
    end
    Idle = 1'b0;
    Send = 1'b0;
    Data_pin_in = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic bad;
    WriteRead = 1'b1;
    Data_from_FIFO = $urandom;
    Send = 1'b1;
    tick();
    Send = 1'b0;
    repeat (20) tick();
    Reset = 1'b0;
    tick();
    n_cmp++;
    if (Data_pin_oe !== 1'b0 || Serial_ready !== 1'b1 ||
        Data_pin_out !== 1'b1 || ReadEn !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_tx: oe %b ready %b out %b re %b want 0 1 1 0",
               Data_pin_oe, Serial_ready, Data_pin_out, ReadEn);
    end
    Reset = 1'b1;
    tick();
    WriteRead = 1'b0;
    Data_pin_in = 1'b1;
    Send = 1'b1;
    tick();
    Send = 1'b0;
    Data_pin_in = 1'b0;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 31; i++) begin
      Data_pin_in = 1'($urandom_range(0, 1));
      tick();
      if (WriteEn !== 1'b0) bad = 1'b1;
    end
    Data_pin_in = 1'($urandom_range(0, 1));
    Reset = 1'b0;
    tick();
    n_cmp++;
    if (bad || WriteEn !== 1'b0 || Data_to_FIFO !== 32'h0 ||
        Serial_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_rx: early %b we %b data %h ready %b want 0 0 0 1",
               bad, WriteEn, Data_to_FIFO, Serial_ready);
    end
    Reset = 1'b1;
    Data_pin_in = 1'b1;
    tick();
  endtask

  initial begin
    int fl;
    test_reset();
    test_tx(32'h0, 32'h0, 0, -1);
    test_tx(32'hA5A5_0F0F, 32'h1234_5678, 3, -1);
    test_rx(32'hDEAD_BEEF, $urandom, -1, 1'b1, 2);
    test_rx(32'hDEAD_BEEF, 32'h0BAD_F00D, int'($urandom_range(0, 15)), 1'b1, 0);
    test_rx(32'hDEAD_BEEF, 32'h0BAD_F00D, -1, 1'b0, 1);
    repeat (4) test_tx($urandom, $urandom, int'($urandom_range(0, 5)), -1);
    repeat (4) begin
      fl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
      test_rx($urandom, $urandom, fl, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 5)));
    end
    test_rx_timeout(16'd70);
    test_rx_timeout(16'd0);
    test_rx_timeout(16'($urandom_range(1, 20)));
    test_tx($urandom, $urandom, 0, int'($urandom_range(0, 8)));
    Timeout_enable = 1'b1;
    Timeout_reg = 16'd9;
    test_rx($urandom, $urandom, -1, 1'b1, 9);
    Timeout_enable = 1'b0;
    test_abort_tx();
    test_tx($urandom, $urandom, 2, -1);
    test_abort_rx();
    test_rx($urandom, $urandom, -1, 1'b1, 0);
    test_reset_mid();
    test_tx($urandom, $urandom, 1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
